md_sequencer: RTL
=================

// Module: md_sequencer
// PURPOSE
//  Execute-stage multiply/divide sequencer. Accepts MDCtrl ops (mult, multu, div, divu, mthi, mtlo) with
//  rs/rt operands and runs the multi-cycle latency countdown. Commits results to the HI/LO registers.
//  Drives Busy so the hazard unit stalls D-stage mult/div/mfhi/mflo until HI/LO are valid.
//  Start/Flush come from E-stage control; HI/LO feed the E-stage HILOSel mux.
// PARAMETERS
//  MULT_CYC  5   cycles Busy stays high for mult/multu (>=1)
//  DIV_CYC   10  cycles Busy stays high for div/divu (>=1)
// PORTS
//  clk      in   1   clock, all state on rising edge
//  reset    in   1   asynchronous, active-low reset
//  Start    in   1   E-stage holds a valid MD instruction this cycle
//  Flush    in   1   exception/interrupt in this cycle; cancels a Start in the same cycle
//  MDCtrl   in   4   0 MULT, 1 DIV, 2 MULTU, 3 DIVU, 4 MTHI, 5 MTLO, 15 none (other codes = none)
//  A        in   32  rs operand
//  B        in   32  rt operand
//  Busy     out  1   multi-cycle op in progress; HI/LO not yet valid
//  Done     out  1   one-cycle pulse, cycle HI/LO first show a mult/div result
//  HI       out  32  HI register
//  LO       out  32  LO register
// BEHAVIOUR
//  - Reset (reset=0, async): state IDLE, counter=0, Busy=0, Done=0, HI=0, LO=0, operand/result regs=0.
//  - Accept = Start & ~Flush & state==IDLE. Start while RUN is ignored (the hazard unit prevents it).
//  - MTHI/MTLO accepted: HI<=A or LO<=A at the same edge; no Busy, no Done; single-cycle.
//  - MULT/MULTU accepted at cycle 0: latch the 64-bit product of A,B (signed / unsigned) into the result reg.
//    state->RUN, counter<=MULT_CYC. Busy=1 in cycles 1..MULT_CYC.
//  - DIV/DIVU accepted: latch LO_res=quotient, HI_res=remainder (signed: truncate toward zero, remainder takes
//    the sign of the dividend), counter<=DIV_CYC.
//  - RUN: the counter decrements each cycle. At the edge ending the cycle where counter==1: HI/LO<=result,
//    state->IDLE, Busy->0, Done=1 for exactly the next cycle. Total: result visible in cycle N+1, N=MULT_CYC/DIV_CYC.
//  - Divide by zero (B==0 at accept): runs full DIV_CYC latency, Done pulses, HI/LO left unchanged.
//  - Signed overflow 0x80000000/-1: LO=0x80000000, HI=0; no trap.
//  - Flush does not abort an op already in RUN; the op completes (instruction already past E).
//  - Reset mid-RUN: immediate return to IDLE; the pending result is discarded and HI/LO are zeroed.
//  - Busy is registered (no comb path from Start); hazard unit ORs Start itself for same-cycle stall.
//  - Unknown MDCtrl with Start=1: no state change.
// TESTING
//  1 mult A=0xFFFFFFFF,B=2 -> Busy cycles 1..5, Done at cycle 6, HI=0xFFFFFFFF, LO=0xFFFFFFFE.
//  2 multu same ops -> HI=0x00000001, LO=0xFFFFFFFE; div A=-7,B=2 -> after 10 cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF.
//  3 divu A=7,B=0 with HI/LO preloaded 0x11/0x22 -> Done pulses at cycle 11, HI=0x11, LO=0x22 unchanged.
//  4 mthi A=0xDEAD then mtlo A=0xBEEF on back-to-back cycles -> HI=0xDEAD, LO=0xBEEF next cycle; Busy never 1.
//  5 Start+Flush together with mult -> Busy stays 0, HI/LO unchanged; Start during RUN -> ignored, first result kept.
//  6 reset=0 asserted mid-div at cycle 4 -> Busy=0, HI=LO=0 immediately (async), no Done after reset release.

Source files
------------

// File: rtl/md_sequencer_if.sv
// ============================================================================
//  Module      : md_sequencer_if
//  Description : E-stage <-> multiply/divide sequencer bundle. Carries the
//                op request (Start/Flush/MDCtrl/A/B) and the HI/LO state
//                plus Busy/Done status back to the pipeline.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface md_sequencer_if;
    logic        Start;
    logic        Flush;
    logic [3:0]  MDCtrl;
    logic [31:0] A;
    logic [31:0] B;
    logic        Busy;
    logic        Done;
    logic [31:0] HI;
    logic [31:0] LO;

    // Pipeline side: issues ops, observes HI/LO and status
    modport master (
        output Start, Flush, MDCtrl, A, B,
        input  Busy, Done, HI, LO
    );

    // Sequencer side
    modport slave (
        input  Start, Flush, MDCtrl, A, B,
        output Busy, Done, HI, LO
    );
endinterface

`default_nettype wire

// File: rtl/md_sequencer.sv
// ============================================================================
//  Module      : md_sequencer
//  Description : Execute-stage multiply/divide sequencer. Computes the
//                64-bit product or quotient/remainder at accept time, then
//                holds Busy for a fixed latency before committing the result
//                to HI/LO and pulsing Done for one cycle.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module md_sequencer #(
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10
) (
    input  wire logic        clk,
    input  wire logic        reset,   // asynchronous, active-low
    md_sequencer_if.slave    bus
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam logic [3:0] OP_MULT  = 4'd0;
    localparam logic [3:0] OP_DIV   = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIVU  = 4'd3;
    localparam logic [3:0] OP_MTHI  = 4'd4;
    localparam logic [3:0] OP_MTLO  = 4'd5;

    localparam int CNT_MAX = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] CNT_MULT = CW'(MULT_CYC);
    localparam logic [CW-1:0] CNT_DIV  = CW'(DIV_CYC);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic            busy_q;
    logic            done_q;
    logic [31:0]     hi_q;
    logic [31:0]     lo_q;
    logic [31:0]     res_hi_q;
    logic [31:0]     res_lo_q;
    logic            res_wr_q;   // clear for divide-by-zero: HI/LO untouched

    // ------------------------------------------------------------------
    // Decode and arithmetic (evaluated on the accept cycle operands)
    // ------------------------------------------------------------------
    logic            w_accept;
    logic            w_is_mult;
    logic            w_is_div;
    logic            w_div_signed;

    logic [63:0]     w_a_sx;
    logic [63:0]     w_b_sx;
    logic [63:0]     w_prod_s;
    logic [63:0]     w_prod_u;
    logic [63:0]     w_prod;

    logic            w_a_neg;
    logic            w_b_neg;
    logic [31:0]     w_a_mag;
    logic [31:0]     w_b_mag;
    logic [31:0]     w_b_safe;
    logic [31:0]     w_q_mag;
    logic [31:0]     w_r_mag;
    logic [31:0]     w_quot;
    logic [31:0]     w_rem;

    assign w_accept     = bus.Start & ~bus.Flush & (state_q == IDLE);
    assign w_is_mult    = (bus.MDCtrl == OP_MULT) || (bus.MDCtrl == OP_MULTU);
    assign w_is_div     = (bus.MDCtrl == OP_DIV)  || (bus.MDCtrl == OP_DIVU);
    assign w_div_signed = (bus.MDCtrl == OP_DIV);

    // Products are formed at 64 bits on sign- or zero-extended operands so
    // the truncated result is the exact full-width product.
    assign w_a_sx   = {{32{bus.A[31]}}, bus.A};
    assign w_b_sx   = {{32{bus.B[31]}}, bus.B};
    assign w_prod_s = w_a_sx * w_b_sx;
    assign w_prod_u = {32'd0, bus.A} * {32'd0, bus.B};
    assign w_prod   = (bus.MDCtrl == OP_MULT) ? w_prod_s : w_prod_u;

    // Signed division is done on magnitudes so that 0x80000000 / -1 wraps
    // to 0x80000000 rem 0 without relying on signed-divide overflow
    // behaviour. Divisor is forced non-zero; the divide-by-zero result is
    // never committed anyway.
    assign w_a_neg  = w_div_signed & bus.A[31];
    assign w_b_neg  = w_div_signed & bus.B[31];
    assign w_a_mag  = w_a_neg ? (32'd0 - bus.A) : bus.A;
    assign w_b_mag  = w_b_neg ? (32'd0 - bus.B) : bus.B;
    assign w_b_safe = (w_b_mag == 32'd0) ? 32'd1 : w_b_mag;
    assign w_q_mag  = w_a_mag / w_b_safe;
    assign w_r_mag  = w_a_mag % w_b_safe;
    // Quotient truncates toward zero; remainder follows the dividend sign
    assign w_quot   = (w_a_neg ^ w_b_neg) ? (32'd0 - w_q_mag) : w_q_mag;
    assign w_rem    = w_a_neg ? (32'd0 - w_r_mag) : w_r_mag;

    // ------------------------------------------------------------------
    // Sequencer FSM: accept, latency countdown, commit to HI/LO
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            res_hi_q <= 32'd0;
            res_lo_q <= 32'd0;
            res_wr_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (w_accept) begin
                        if (w_is_mult) begin
                            res_hi_q <= w_prod[63:32];
                            res_lo_q <= w_prod[31:0];
                            res_wr_q <= 1'b1;
                            cnt_q    <= CNT_MULT;
                            busy_q   <= 1'b1;
                            state_q  <= RUN;
                        end else if (w_is_div) begin
                            res_hi_q <= w_rem;
                            res_lo_q <= w_quot;
                            res_wr_q <= (bus.B != 32'd0);
                            cnt_q    <= CNT_DIV;
                            busy_q   <= 1'b1;
                            state_q  <= RUN;
                        end else if (bus.MDCtrl == OP_MTHI) begin
                            hi_q <= bus.A;
                        end else if (bus.MDCtrl == OP_MTLO) begin
                            lo_q <= bus.A;
                        end
                    end
                end
                RUN: begin
                    // Start/Flush are ignored here: the op is already past E
                    if (cnt_q == CNT_ONE) begin
                        if (res_wr_q) begin
                            hi_q <= res_hi_q;
                            lo_q <= res_lo_q;
                        end
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.Busy = busy_q;
    assign bus.Done = done_q;
    assign bus.HI   = hi_q;
    assign bus.LO   = lo_q;

endmodule

`default_nettype wire
